// File: rtl/vga_segdac_engine.sv
// VGA timing generator driving segmented thermometer-coded colour DACs with a
// bias power sequence (OFF -> SETTLE -> RUN) and built-in test patterns.
module vga_segdac_engine #(
  parameter int CHANNELS      = 3,
  parameter int SEGS          = 4,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [1:0]                 bias_lvl,
  input  logic [CHANNELS*2*SEGS-1:0] pix_in,
  output logic [CHANNELS*3*SEGS-1:0] code,
  output logic [CHANNELS*3-1:0]      bias_en,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic [15:0]                h_pos,
  output logic [15:0]                v_pos
);

  localparam int LVL_W  = 2 * SEGS;
  localparam int PIX_W  = CHANNELS * LVL_W;
  localparam int CODE_W = CHANNELS * 3 * SEGS;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
  localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] BAR_W      = 16'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic [15:0]       r_h;
  logic [15:0]       r_v;
  logic [15:0]       w_h_nxt;
  logic [15:0]       w_v_nxt;
  logic [1:0]        r_mode;
  logic [2:0]        w_bar;
  logic [PIX_W-1:0]  w_pix;
  logic [CODE_W-1:0] w_code;
  logic              w_run;
  logic              w_active;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic [CODE_W-1:0] r_code;
  logic [CHANNELS*3-1:0] r_bias_en;
  logic              r_de;
  logic              r_hsync;
  logic              r_vsync;

  // Switch j (bit j-1) closes when the level reaches j.
  function automatic logic [2:0] therm(input logic [1:0] lvl);
    return {&lvl, lvl[1], |lvl};
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:    w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
      ST_RUN:    w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_OFF;
    endcase
    if (!enable) w_state_nxt = ST_OFF;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (r_state == ST_RUN && w_state_nxt == ST_RUN) begin
      if (r_h == H_LAST) begin
        w_v_nxt = (r_v == V_LAST) ? 16'd0 : r_v + 16'd1;
      end else begin
        w_h_nxt = r_h + 16'd1;
        w_v_nxt = r_v;
      end
    end
  end

  // Pixel source per latched mode, then per-segment thermometer expansion.
  always_comb begin
    w_bar  = 3'(r_h / BAR_W);
    w_pix  = '0;
    w_code = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (r_mode)
        2'd0:    w_pix[c*LVL_W +: LVL_W] = pix_in[c*LVL_W +: LVL_W];
        2'd1:    w_pix[c*LVL_W +: LVL_W] = {LVL_W{w_bar[c%3]}};
        2'd2:    w_pix[c*LVL_W +: LVL_W] = LVL_W'(r_h);
        default: w_pix[c*LVL_W +: LVL_W] = '0;
      endcase
      for (int k = 0; k < SEGS; k++) begin
        w_code[c*3*SEGS + 3*k +: 3] = therm(w_pix[c*LVL_W + 2*k +: 2]);
      end
    end
  end

  assign w_run     = (r_state == ST_RUN) && enable;
  assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hsync_n = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
  assign w_vsync_n = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_mode       <= 2'd3;
      r_code       <= '0;
      r_bias_en    <= '0;
      r_de         <= 1'b0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
    end else begin
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + CNT_W'(1) : '0;
      r_h          <= w_h_nxt;
      r_v          <= w_v_nxt;
      // Mode only changes at the first pixel of a frame, including RUN entry.
      if (w_state_nxt == ST_RUN && w_h_nxt == '0 && w_v_nxt == '0) r_mode <= mode;
      r_bias_en    <= (w_state_nxt != ST_OFF) ? {CHANNELS{therm(bias_lvl)}} : '0;
      r_de         <= w_run && w_active;
      r_code       <= (w_run && w_active) ? w_code : '0;
      r_hsync      <= w_run ? w_hsync_n : 1'b1;
      r_vsync      <= w_run ? w_vsync_n : 1'b1;
    end
  end

  assign code    = r_code;
  assign bias_en = r_bias_en;
  assign de      = r_de;
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign h_pos   = r_h;
  assign v_pos   = r_v;

endmodule

// File: tb/tb_vga_segdac_engine.sv
// Scoreboard bench for vga_segdac_engine: a cycle-count model predicts every
// output each clock, plus directed checks on timing, patterns and power-down.
module tb_vga_segdac_engine;

  localparam int CH = 3, SG = 4;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int S  = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME  = HT * VT;
  localparam int LVL_W  = 2 * SG;
  localparam int PIX_W  = CH * LVL_W;
  localparam int CODE_W = CH * 3 * SG;
  localparam int BIAS_W = CH * 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [1:0]        mode;
  logic [1:0]        bias_lvl;
  logic [PIX_W-1:0]  pix_in;
  logic [CODE_W-1:0] code;
  logic [BIAS_W-1:0] bias_en;
  logic              hsync, vsync, de;
  logic [15:0]       h_pos, v_pos;

  vga_segdac_engine #(
    .CHANNELS(CH), .SEGS(SG),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .bias_lvl(bias_lvl),
    .pix_in(pix_in), .code(code), .bias_en(bias_en), .hsync(hsync), .vsync(vsync),
    .de(de), .h_pos(h_pos), .v_pos(v_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic              de, hs, vs;
    logic [BIAS_W-1:0] bias;
    logic [15:0]       h, v;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned m_k = 0;
  logic [1:0]  m_mode = 2'd3;
  longint      cyc = 0;
  bit          hold_pix = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [2:0] therm3(input logic [1:0] lvl);
    logic [2:0] t;
    for (int j = 1; j <= 3; j++) t[j-1] = (int'(lvl) >= j);
    return t;
  endfunction

  function automatic logic [CODE_W-1:0] pix_code(input logic [1:0] md, input int h,
                                                  input logic [PIX_W-1:0] pix);
    logic [CODE_W-1:0] r;
    logic [LVL_W-1:0]  val;
    int                bar;
    r   = '0;
    bar = h / (HA / 8);
    for (int c = 0; c < CH; c++) begin
      case (md)
        2'd0:    val = pix[c*LVL_W +: LVL_W];
        2'd1:    val = (((bar >> (c % 3)) & 1) != 0) ? {LVL_W{1'b1}} : '0;
        2'd2:    val = LVL_W'(h % (1 << LVL_W));
        default: val = '0;
      endcase
      for (int k = 0; k < SG; k++) r[c*3*SG + 3*k +: 3] = therm3(val[2*k +: 2]);
    end
    return r;
  endfunction

  // Model state is just the count of consecutive enabled edges since power-up.
  function automatic exp_t model_out(input int unsigned k, input logic [1:0] md,
                                     input logic rn, input logic en,
                                     input logic [PIX_W-1:0] pix, input logic [1:0] bl);
    exp_t        e;
    int unsigned kn, t, h, v;
    e = '{code: '0, de: 1'b0, hs: 1'b1, vs: 1'b1, bias: '0, h: 16'd0, v: 16'd0};
    if (!rn) return e;
    kn = en ? k + 1 : 0;
    if (en && k >= S + 1) begin
      t = k - S - 1;
      h = t % HT;
      v = (t / HT) % VT;
      if (h < HA && v < VA) begin
        e.de   = 1'b1;
        e.code = pix_code(md, int'(h), pix);
      end
      e.hs = !(h >= HA + HF && h < HA + HF + HS);
      e.vs = !(v >= VA + VF && v < VA + VF + VS);
    end
    if (kn > 0) e.bias = {CH{therm3(bl)}};
    if (kn >= S + 1) begin
      t   = kn - S - 1;
      e.h = 16'(t % HT);
      e.v = 16'((t / HT) % VT);
    end
    return e;
  endfunction

  function automatic logic [1:0] next_mode(input int unsigned k, input logic [1:0] md,
                                           input logic rn, input logic en, input logic [1:0] md_in);
    int unsigned kn;
    if (!rn) return 2'd3;
    kn = en ? k + 1 : 0;
    if (kn >= S + 1 && ((kn - S - 1) % FRAME) == 0) return md_in;
    return md;
  endfunction

  function automatic logic [47:0] pack_out(input exp_t e);
    return {e.code, e.de, e.hs, e.vs, e.bias};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sb_q.push_back(model_out(m_k, m_mode, rst_n, enable, pix_in, bias_lvl));
    m_mode <= next_mode(m_k, m_mode, rst_n, enable, mode);
    m_k    <= (!rst_n || !enable) ? 0 : m_k + 1;
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      check("sb_out", {code, de, hsync, vsync, bias_en}, pack_out(sb_q[0]));
      check("sb_pos", {h_pos, v_pos}, {sb_q[0].h, sb_q[0].v});
      void'(sb_q.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    if (!hold_pix) pix_in = PIX_W'($urandom());
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(int'(h_pos) == h && int'(v_pos) == v) && n < 3 * FRAME) begin
      step();
      n++;
    end
    check("wait_pos", {h_pos, v_pos}, {16'(h), 16'(v)});
  endtask

  task automatic wait_sync(input bit is_v, input logic val);
    int n = 0;
    while (((is_v ? vsync : hsync) !== val) && n < 3 * FRAME) begin
      step();
      n++;
    end
    check(is_v ? "vsync_wait" : "hsync_wait", is_v ? vsync : hsync, val);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n;
    longint t0, t1;
    rst_n = 1'b0; enable = 1'b1; mode = 2'd0; bias_lvl = 2'd2; pix_in = '0;

    repeat (3) step();
    check("rst_out", {code, de, hsync, vsync, bias_en}, {36'h0, 1'b0, 1'b1, 1'b1, 9'h0});
    check("rst_pos", {h_pos, v_pos}, 32'h0);

    rst_n = 1'b1;
    step();
    check("bias_on", bias_en, 9'b011_011_011);
    n = 0;
    while (!de && n < S + 50) begin step(); n++; end
    check("first_de_lat", n, S + 1);
    check("first_de_pos", {h_pos, v_pos}, {16'd1, 16'd0});

    wait_pos(100, 1);
    hold_pix = 1'b1;
    pix_in = PIX_W'($urandom());
    pix_in[7:0] = 8'b11_10_01_00;
    step();
    hold_pix = 1'b0;
    check("pix_ch0", code[11:0], 12'b111_011_001_000);

    wait_sync(1'b0, 1'b0);
    check("hs_fall_h", h_pos, 16'(HA + HF + 1));
    t0 = cyc;
    wait_sync(1'b0, 1'b1);
    check("hs_low_len", cyc - t0, HS);
    wait_sync(1'b0, 1'b0);
    check("line_period", cyc - t0, HT);

    wait_sync(1'b1, 1'b0);
    check("vs_fall_pos", {h_pos, v_pos}, {16'd1, 16'(VA + VF)});
    t1 = cyc;
    wait_sync(1'b1, 1'b1);
    check("vs_low_len", cyc - t1, VS * HT);
    mode = 2'd1;
    bias_lvl = 2'd3;

    wait_pos(241, 1);
    check("bars_b3", {code, de}, {36'h000_FFF_FFF, 1'b1});
    wait_pos(0, 3);
    mode = 2'd3;
    wait_pos(241, 4);
    check("bars_hold", code, 36'h000_FFF_FFF);
    wait_sync(1'b1, 1'b0);
    check("frame_period", cyc - t1, FRAME);
    wait_pos(241, 0);
    check("black_de", {code, de}, {36'h0, 1'b1});
    mode = 2'd2;

    wait_pos(300, 2);
    enable = 1'b0;
    step();
    check("drop_out", {code, de, hsync, vsync, bias_en}, {36'h0, 1'b0, 1'b1, 1'b1, 9'h0});
    check("drop_pos", {h_pos, v_pos}, 32'h0);

    repeat (5) step();
    bias_lvl = 2'd1;
    enable = 1'b1;
    step();
    check("rebias", bias_en, 9'b001_001_001);
    n = 0;
    while (!de && n < S + 50) begin step(); n++; end
    check("re_settle", n, S + 1);

    repeat (40) step();
    rst_n = 1'b0;
    step();
    check("rst_mid", {code, de, hsync, vsync, bias_en}, {36'h0, 1'b0, 1'b1, 1'b1, 9'h0});
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
